// File: rtl/setpoint_interpolator_pkg.sv
// Shared types and width helpers for the setpoint interpolator.
package setpoint_interp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // Accumulator carries one guard bit above the sample plus log2_steps fraction bits.
    function automatic int acc_width(input int nb, input int ls);
        return nb + 1 + ls;
    endfunction

    function automatic int delta_width(input int nb);
        return nb + 1;
    endfunction

endpackage

// File: rtl/setpoint_interpolator_if.sv
// Target-setpoint handshake between the lock controller and the interpolator.
interface setpoint_interpolator_if #(
    parameter int num_bits = 16
) ();
    logic signed [num_bits-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/setpoint_interpolator.sv
// Linear ramp from the current output to each accepted target in 2^log2_steps clocks.
// Optional mid-ramp retargeting is enabled by defining SETPOINT_INTERP_RETARGET_EN.
module setpoint_interpolator
    import setpoint_interp_pkg::*;
#(
    parameter int num_bits   = 16,
    parameter int log2_steps = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    setpoint_interpolator_if.slave     in_if,
    input  logic                       freeze,
    output logic signed [num_bits-1:0] out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = acc_width(num_bits, log2_steps);
    localparam int DW = delta_width(num_bits);
    localparam int CW = log2_steps;
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
`ifdef SETPOINT_INTERP_RETARGET_EN
    localparam logic RETARGET = 1'b1;
`else
    localparam logic RETARGET = 1'b0;
`endif

    state_t                     state_q, state_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic signed [DW-1:0]       delta_q, delta_d;
    logic        [CW-1:0]       cnt_q, cnt_d;
    logic signed [num_bits-1:0] out_q, out_d;
    logic                       in_ready_q, in_ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       accept_s;
    logic signed [DW-1:0]       new_delta_s;
    logic signed [AW-1:0]       load_acc_s;
    logic signed [AW-1:0]       delta_ext_s;

    assign accept_s    = in_if.in_valid && in_ready_q;
    assign new_delta_s = {in_if.in_data[num_bits-1], in_if.in_data} - {out_q[num_bits-1], out_q};
    // Reloading from out_q drops any fraction left over from an abandoned ramp.
    assign load_acc_s  = {out_q[num_bits-1], out_q, {CW{1'b0}}};
    assign delta_ext_s = {{CW{delta_q[DW-1]}}, delta_q};

    // Next-state logic for FSM, accumulator, step counter and status flags.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        delta_d    = delta_q;
        cnt_d      = cnt_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (accept_s) begin
                    delta_d    = new_delta_s;
                    acc_d      = load_acc_s;
                    cnt_d      = {CW{1'b0}};
                    state_d    = RAMP;
                    busy_d     = 1'b1;
                    in_ready_d = RETARGET;
                end else begin
                    state_d = IDLE;
                end
            end
            RAMP: begin
                if (RETARGET && accept_s) begin
                    delta_d = new_delta_s;
                    acc_d   = load_acc_s;
                    cnt_d   = {CW{1'b0}};
                    state_d = RAMP;
                end else if (!freeze) begin
                    acc_d = acc_q + delta_ext_s;
                    cnt_d = cnt_q + CW'(1'b1);
                    if (cnt_q == CNT_LAST) begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        state_d = RAMP;
                    end
                end else begin
                    state_d = RAMP;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
        out_d = acc_d[CW +: num_bits];
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= {AW{1'b0}};
            delta_q    <= {DW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            out_q      <= {num_bits{1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            delta_q    <= delta_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign out_data       = out_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_setpoint_interpolator.sv
// Scoreboard bench for setpoint_interpolator with log2_steps=2 and directed targets.
module tb_setpoint_interpolator;

    localparam int NB = 16;
    localparam int LS = 2;
`ifdef SETPOINT_INTERP_RETARGET_EN
    localparam logic RT = 1'b1;
`else
    localparam logic RT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 freeze = 1'b0;
    logic signed [NB-1:0] out_data;
    logic                 busy;
    logic                 done;

    setpoint_interpolator_if #(.num_bits(NB)) bus ();

    setpoint_interpolator #(.num_bits(NB), .log2_steps(LS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (bus),
        .freeze   (freeze),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [NB-1:0] out;
        logic                 busy;
        logic                 done;
        logic                 rdy;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic signed [NB-1:0] o, input logic b, input logic d);
        rec_t r;
        r.out  = o;
        r.busy = b;
        r.done = d;
        r.rdy  = b ? RT : 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT is ramping or finishing is compared to the next expected record.
    always @(negedge clk) begin
        if (rst && (busy || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual out=%0d busy=%0b done=%0b required=no output",
                         out_data, busy, done);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.out || busy !== mon_e.busy || done !== mon_e.done ||
                    bus.in_ready !== mon_e.rdy) begin
                    errors++;
                    $display("FAIL ramp_step actual out=%0d busy=%0b done=%0b rdy=%0b required out=%0d busy=%0b done=%0b rdy=%0b",
                             out_data, busy, done, bus.in_ready,
                             mon_e.out, mon_e.busy, mon_e.done, mon_e.rdy);
                end
            end
        end
    end

    task automatic offer(input logic signed [NB-1:0] v);
        int n;
        @(negedge clk);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout actual in_ready=%0b required=1", bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #12;
        check("rst_out", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("ready_before_edge", bus.in_ready, 0);
        @(posedge clk);
        #1 check("ready_after_edge", bus.in_ready, 1);

        // Basic ramp up and back down.
        push(0, 1, 0); push(25, 1, 0); push(50, 1, 0); push(75, 1, 0); push(100, 0, 1);
        offer(100);
        wait_drain();
        push(100, 1, 0); push(50, 1, 0); push(0, 1, 0); push(-50, 1, 0); push(-100, 0, 1);
        offer(-100);
        wait_drain();

        // Climb to full scale, then full-scale swing to the negative rail.
        push(-100, 1, 0); push(8116, 1, 0); push(16333, 1, 0); push(24550, 1, 0); push(32767, 0, 1);
        offer(32767);
        wait_drain();
        push(32767, 1, 0); push(16383, 1, 0); push(-1, 1, 0); push(-16385, 1, 0); push(-32768, 0, 1);
        offer(-32768);
        wait_drain();

        // Freeze held during an IDLE handshake must not block acceptance.
        freeze = 1'b1;
        push(-32768, 1, 0); push(-24576, 1, 0); push(-16384, 1, 0); push(-8192, 1, 0); push(0, 0, 1);
        offer(0);
        freeze = 1'b0;
        wait_drain();

        // Freeze for three edges after the second step.
        push(0, 1, 0); push(25, 1, 0); push(50, 1, 0);
        push(50, 1, 0); push(50, 1, 0); push(50, 1, 0);
        push(75, 1, 0); push(100, 0, 1);
        offer(100);
        @(posedge clk);
        @(posedge clk);
        #1 freeze = 1'b1;
        repeat (3) @(posedge clk);
        #1 freeze = 1'b0;
        wait_drain();

        // Reset pulled mid-ramp at out=50.
        push(100, 1, 0); push(50, 1, 0);
        offer(-100);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_out", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", bus.in_ready, 0);
        check("midrst_queue", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rel_ready_before_edge", bus.in_ready, 0);
        @(posedge clk);
        #1 check("rel_ready_after_edge", bus.in_ready, 1);

`ifdef SETPOINT_INTERP_RETARGET_EN
        // Retarget to 0 while out=50; single done for the new ramp.
        push(0, 1, 0); push(25, 1, 0); push(50, 1, 0);
        offer(100);
        push(50, 1, 0); push(37, 1, 0); push(25, 1, 0); push(12, 1, 0); push(0, 0, 1);
        @(posedge clk);
        @(posedge clk);
        offer(0);
`else
        // Second offer raised mid-ramp is held off until the first ramp completes.
        push(0, 1, 0); push(25, 1, 0); push(50, 1, 0); push(75, 1, 0); push(100, 0, 1);
        offer(100);
        push(100, 1, 0); push(75, 1, 0); push(50, 1, 0); push(25, 1, 0); push(0, 0, 1);
        @(posedge clk);
        offer(0);
`endif
        wait_drain();
        repeat (3) @(negedge clk);
        check("final_out", out_data, 0);
        check("final_ready", bus.in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/setpoint_interpolator.md
Name: setpoint_interpolator

Overview:
- DAC-side counterpart to the ADC-side IIR smoothing filter.
- Accepts sparse signed setpoint updates from the lock controller through a valid/ready handshake.
- Produces a per-clock output that ramps linearly to each new target in exactly 2^log2_steps cycles, so the piezo/laser DAC never sees step changes.
- Sits between the lock-loop output register and the DAC output mux.

Parameters:
- num_bits, 16: sample width, signed two's complement, for in_data and out_data.
- log2_steps, 8: ramp length is 2^log2_steps clocks; legal range 1..16.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_data  input  num_bits  signed target setpoint
- in_valid  input  1  target offered
- in_ready  output  1  block can accept a target
- freeze  input  1  pause ramp; holds output and counter
- out_data  output  num_bits  signed interpolated output, registered
- busy  output  1  ramp in progress (state RAMP)
- done  output  1  one-cycle pulse on ramp completion

Behaviour:
- Reset values (rst low, async): acc=0, out_data=0, delta=0, cnt=0, state=IDLE, in_ready=0, busy=0, done=0.
- in_ready rises on the first clk edge after rst deasserts.
- acc is a signed register of width num_bits+1+log2_steps and holds the output with log2_steps fraction bits.
- out_data = acc >> log2_steps (arithmetic shift, floor), truncated to num_bits; registered alongside acc.
- delta is signed num_bits+1 and equals sign_ext(in_data) - sign_ext(out_data), captured at handshake.
- States: IDLE and RAMP.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready at edge k: latch delta; set acc = out_data << log2_steps (discards any fraction bits); cnt=0; go to RAMP; busy=1 and in_ready=0 from edge k.
- RAMP, each edge with freeze=0:
  - acc += delta; cnt++.
  - When cnt == 2^log2_steps-1 on that edge: go to IDLE, done=1 for exactly one cycle, in_ready=1, busy=0.
- RAMP with freeze=1: acc, cnt and state hold; done is not asserted.
- Latency: out_data first changes at edge k+1. out_data equals in_data exactly from edge k+2^log2_steps (no freeze), the same edge on which done pulses.
- Exactness: the sum of 2^log2_steps additions of delta equals delta<<log2_steps, so there is no residual error and no overshoot.
- delta=0: a full-length ramp still runs, with constant output and done at the usual time.
- Full-scale swing (0x7FFF to 0x8000 or back): delta spans 17 bits with no overflow, and out_data stays monotonic.
- freeze in IDLE has no effect; the handshake is still accepted.
- rst asserted mid-ramp: immediate return to reset values; out_data goes to 0.
- in_valid while in_ready=0: ignored. The sender must hold in_valid until it sees in_ready.

Optional Feature:
- Macro: SETPOINT_INTERP_RETARGET_EN.
- Defined:
  - in_ready=1 in RAMP as well.
  - A handshake mid-ramp recomputes delta from the current out_data, sets acc = out_data << log2_steps and cnt=0, and stays in RAMP.
  - No done pulse is produced for the abandoned ramp.
  - Retarget together with freeze=1 is accepted; the first addition happens on the next unfrozen edge.
- Undefined: in_ready=0 throughout RAMP, and targets are accepted only in IDLE.

Decomposition:
- Package setpoint_interp_pkg:
  - state enum {IDLE, RAMP}.
  - Localparam-style functions for acc width (num_bits+1+log2_steps) and delta width (num_bits+1).
- No sub-module. Counter, accumulator and FSM live in one module.

Test Plan:
- log2_steps=2, from reset, target 100 → in_ready at edge 1; out_data 25,50,75,100 on consecutive edges; done one cycle with out=100.
- log2_steps=2, out=100, target -100 (0xFF9C) → out_data 50,0,-50,-100; busy high exactly 4 cycles.
- log2_steps=2, out=0x7FFF, target 0x8000 → out_data 16383,-1,-16385,-32768; no wrap glitch.
- log2_steps=2, target 100, freeze high for 3 cycles after the 2nd step → out stays at 50 for 3 cycles, then 75,100; done delayed 3 cycles.
- rst pulled low mid-ramp at out=50 → out_data=0, busy=0, done=0 immediately; in_ready=1 one edge after release.
- With SETPOINT_INTERP_RETARGET_EN, log2_steps=2: target 100, then target 0 at out=50 → out 37,25,12,0 (floor); single done pulse. Without the macro, the second offer is held off until done.
